wb_pix_master: RTL and testbench



---
 rtl/wb_pix_master.sv | 197 +++++++++++++++++++
 tb/tb_wb_pix_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pix_master.sv
// wb_pix_master: Wishbone classic single-transfer initiator.
// Each command accepted on the valid/ready port becomes one Wishbone read or
// write. The outcome (read data, or a timeout error) comes back on a
// one-cycle response strobe. All outputs are driven straight from flops.
//
// Optional build macro WB_SEQ_RETRY_EN: the first timeout of a command drops
// cyc/stb for one cycle (GAP) and retries the same transfer once. Only the
// second timeout reports an error. When the macro is undefined, the first
// timeout reports the error immediately.
module wb_pix_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TO_W           = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
`ifdef WB_SEQ_RETRY_EN
    localparam logic [1:0] ST_GAP  = 2'd3;
`endif

    // Counter value seen on the last edge before the transfer is abandoned.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic            cyc_q, cyc_d;
    logic            we_q, we_d;
    logic [31:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic [3:0]      sel_q, sel_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_dat_q, rsp_dat_d;
    logic            rsp_err_q, rsp_err_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            busy_q, busy_d;
`ifdef WB_SEQ_RETRY_EN
    logic            retry_q, retry_d;
`endif

    // Next-state logic: command capture, bus wait with timeout, and response.
    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cmd_ready_d = cmd_ready_q;
`ifdef WB_SEQ_RETRY_EN
        retry_d     = retry_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    we_d        = cmd_we;
                    adr_d       = cmd_adr;
                    dat_d       = cmd_dat;
                    sel_d       = cmd_sel;
                    cyc_d       = 1'b1;
                    cnt_d       = '0;
                    cmd_ready_d = 1'b0;
                    state_d     = ST_BUS;
`ifdef WB_SEQ_RETRY_EN
                    retry_d     = 1'b0;
`endif
                end
            end

            ST_BUS: begin
                if (wbm_ack_i) begin
                    // An ack wins over a timeout that lands on the same edge.
                    cyc_d       = 1'b0;
                    rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    cyc_d = 1'b0;
`ifdef WB_SEQ_RETRY_EN
                    if (!retry_q) begin
                        retry_d = 1'b1;
                        state_d = ST_GAP;
                    end else begin
`endif
                        rsp_dat_d   = 32'd0;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
`ifdef WB_SEQ_RETRY_EN
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RESP: begin
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end

`ifdef WB_SEQ_RETRY_EN
            ST_GAP: begin
                // One idle bus cycle, then retry with the latched fields.
                cyc_d   = 1'b1;
                cnt_d   = '0;
                state_d = ST_BUS;
            end
`endif

            default: begin
                cyc_d       = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers. Reset clears the bus cycle at once, without waiting for a clock.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            sel_q       <= 4'd0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= 32'd0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef WB_SEQ_RETRY_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
`ifdef WB_SEQ_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;

endmodule

// File: tb/tb_wb_pix_master.sv
// Directed testbench for wb_pix_master with a small Wishbone slave model.
module tb_wb_pix_master;

    localparam int unsigned TO = 8;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = 32'd0;
    logic [31:0] cmd_dat = 32'd0;
    logic [3:0]  cmd_sel = 4'd0;
    logic        rsp_valid;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_dat_i = 32'd0;
    logic        wbm_ack_i;

    int n_cmp = 0;
    int n_fail = 0;

    // Slave model controls.
    int          slv_waits = 1000;
    logic [31:0] slv_rdata = 32'd0;
    bit          slv_adr_mode = 1'b0;
    logic        slv_ack = 1'b0;
    logic        force_ack = 1'b0;
    int          slv_cnt = 0;

    assign wbm_ack_i = slv_ack | force_ack;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_pix_master #(.TIMEOUT_CYCLES(TO), .TO_W(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    // Slave: acks in the (slv_waits+1)-th cycle of cyc high; counter restarts whenever cyc drops.
    always @(negedge wb_clk_i) begin
        if (wbm_cyc_o) begin
            slv_ack   = (slv_cnt == slv_waits);
            wbm_dat_i = slv_adr_mode ? (wbm_adr_o ^ 32'h5A5A_0000) : slv_rdata;
            slv_cnt   = slv_cnt + 1;
        end else begin
            slv_ack   = 1'b0;
            wbm_dat_i = 32'hDEAD_BEEF;
            slv_cnt   = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        @(posedge wb_clk_i); #1;
        cmd_valid = 1'b0;
    endtask

    // Observes one transfer until rsp_valid; counts cyc-high and cyc-low cycles before it.
    task automatic collect(output int hi, output int lo, output bit got, output bit stable);
        logic [31:0] a, d;
        logic [3:0]  s;
        logic        w;
        bit          first;
        hi = 0; lo = 0; got = 1'b0; stable = 1'b1; first = 1'b1;
        a = '0; d = '0; s = '0; w = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge wb_clk_i);
            if (wbm_stb_o !== wbm_cyc_o) stable = 1'b0;
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
            end else if (wbm_cyc_o === 1'b1) begin
                hi++;
                if (first) begin
                    a = wbm_adr_o; d = wbm_dat_o; s = wbm_sel_o; w = wbm_we_o; first = 1'b0;
                end else if (a !== wbm_adr_o || d !== wbm_dat_o || s !== wbm_sel_o || w !== wbm_we_o) begin
                    stable = 1'b0;
                end
            end else begin
                lo++;
            end
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if ({rsp_valid, rsp_err, busy, wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 6'b0) begin
            n_fail++; $display("FAIL rst_ctrl: got %b want 000000", {rsp_valid, rsp_err, busy, wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
        n_cmp++; if ({rsp_dat, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== 100'd0) begin
            n_fail++; $display("FAIL rst_data: got %h want 0", {rsp_dat, wbm_adr_o, wbm_dat_o, wbm_sel_o}); end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        n_cmp++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_rst_idle: got ready=%b busy=%b want 1 0", cmd_ready, busy); end
    endtask

    task automatic test_write();
        int hi, lo; bit got, stable;
        slv_adr_mode = 1'b0; slv_waits = 0;
        issue(1'b1, 32'h3000_0004, 32'h0000_00A5, 4'hF);
        n_cmp++; if ({wbm_cyc_o, wbm_stb_o, wbm_we_o} !== 3'b111) begin
            n_fail++; $display("FAIL wr_bus_ctrl: got %b want 111", {wbm_cyc_o, wbm_stb_o, wbm_we_o}); end
        n_cmp++; if (wbm_adr_o !== 32'h3000_0004 || wbm_dat_o !== 32'h0000_00A5 || wbm_sel_o !== 4'hF) begin
            n_fail++; $display("FAIL wr_fields: got adr=%h dat=%h sel=%h want 30000004 000000a5 f", wbm_adr_o, wbm_dat_o, wbm_sel_o); end
        n_cmp++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL wr_busy: got ready=%b busy=%b want 0 1", cmd_ready, busy); end
        collect(hi, lo, got, stable);
        n_cmp++; if (got !== 1'b1 || hi != 1 || lo != 0 || stable !== 1'b1) begin
            n_fail++; $display("FAIL wr_cycle: got rsp=%b hi=%0d lo=%0d stable=%b want 1 1 0 1", got, hi, lo, stable); end
        n_cmp++; if (rsp_err !== 1'b0 || rsp_dat !== 32'd0) begin
            n_fail++; $display("FAIL wr_rsp: got err=%b dat=%h want 0 00000000", rsp_err, rsp_dat); end
        @(negedge wb_clk_i);
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL wr_after: got valid=%b ready=%b busy=%b want 0 1 0", rsp_valid, cmd_ready, busy); end
    endtask

    task automatic test_read();
        int hi, lo; bit got, stable;
        slv_adr_mode = 1'b0; slv_waits = 3; slv_rdata = 32'h1234_5678;
        issue(1'b0, 32'h3000_0000, 32'hFFFF_0000, 4'hF);
        n_cmp++; if (wbm_we_o !== 1'b0 || wbm_adr_o !== 32'h3000_0000) begin
            n_fail++; $display("FAIL rd_fields: got we=%b adr=%h want 0 30000000", wbm_we_o, wbm_adr_o); end
        collect(hi, lo, got, stable);
        n_cmp++; if (got !== 1'b1 || hi != 4 || lo != 0 || stable !== 1'b1) begin
            n_fail++; $display("FAIL rd_cycle: got rsp=%b hi=%0d lo=%0d stable=%b want 1 4 0 1", got, hi, lo, stable); end
        n_cmp++; if (rsp_dat !== 32'h1234_5678 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL rd_rsp: got dat=%h err=%b want 12345678 0", rsp_dat, rsp_err); end
        @(negedge wb_clk_i);
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_dat !== 32'h1234_5678) begin
            n_fail++; $display("FAIL rd_hold: got valid=%b ready=%b dat=%h want 0 1 12345678", rsp_valid, cmd_ready, rsp_dat); end
    endtask

    task automatic test_timeout();
        int hi, lo; bit got, stable;
        int exp_hi, exp_lo;
`ifdef WB_SEQ_RETRY_EN
        exp_hi = 2 * TO; exp_lo = 1;
`else
        exp_hi = TO; exp_lo = 0;
`endif
        slv_adr_mode = 1'b0; slv_waits = 1000;
        issue(1'b0, 32'h3000_0010, 32'd0, 4'hF);
        collect(hi, lo, got, stable);
        n_cmp++; if (got !== 1'b1 || hi != exp_hi || lo != exp_lo || stable !== 1'b1) begin
            n_fail++; $display("FAIL to_cycle: got rsp=%b hi=%0d lo=%0d stable=%b want 1 %0d %0d 1", got, hi, lo, stable, exp_hi, exp_lo); end
        n_cmp++; if (rsp_err !== 1'b1 || rsp_dat !== 32'd0) begin
            n_fail++; $display("FAIL to_rsp: got err=%b dat=%h want 1 00000000", rsp_err, rsp_dat); end
        @(negedge wb_clk_i);
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || rsp_err !== 1'b1) begin
            n_fail++; $display("FAIL to_after: got valid=%b ready=%b err=%b want 0 1 1", rsp_valid, cmd_ready, rsp_err); end
    endtask

    task automatic test_late_ack();
        int hi, lo; bit got, stable;
        slv_adr_mode = 1'b0; slv_waits = TO - 1; slv_rdata = 32'hCAFE_0001;
        issue(1'b0, 32'h3000_0014, 32'd0, 4'h1);
        collect(hi, lo, got, stable);
        n_cmp++; if (got !== 1'b1 || hi != TO || lo != 0) begin
            n_fail++; $display("FAIL late_cycle: got rsp=%b hi=%0d lo=%0d want 1 %0d 0", got, hi, lo, TO); end
        n_cmp++; if (rsp_err !== 1'b0 || rsp_dat !== 32'hCAFE_0001) begin
            n_fail++; $display("FAIL late_rsp: got err=%b dat=%h want 0 cafe0001", rsp_err, rsp_dat); end
        @(negedge wb_clk_i);
        n_cmp++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL late_after: got valid=%b ready=%b want 0 1", rsp_valid, cmd_ready); end
    endtask

    task automatic test_ack_idle();
        force_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            n_cmp++; if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
                n_fail++; $display("FAIL idle_ack: got valid=%b cyc=%b busy=%b ready=%b want 0 0 0 1", rsp_valid, wbm_cyc_o, busy, cmd_ready); end
        end
        force_ack = 1'b0;
        n_cmp++; if (rsp_dat !== 32'hCAFE_0001 || rsp_err !== 1'b0) begin
            n_fail++; $display("FAIL idle_hold: got dat=%h err=%b want cafe0001 0", rsp_dat, rsp_err); end
    endtask

    task automatic test_reset_mid();
        slv_adr_mode = 1'b0; slv_waits = 1000;
        issue(1'b1, 32'h3000_0020, 32'h5555_AAAA, 4'h3);
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        n_cmp++; if (wbm_cyc_o !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_bus: got cyc=%b busy=%b want 1 1", wbm_cyc_o, busy); end
        #2 wb_rst_i = 1'b1;
        #1;
        n_cmp++; if ({wbm_cyc_o, wbm_stb_o, rsp_valid, busy} !== 4'b0000 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_async: got cyc=%b stb=%b valid=%b busy=%b ready=%b want 0 0 0 0 1",
                               wbm_cyc_o, wbm_stb_o, rsp_valid, busy, cmd_ready); end
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            n_cmp++; if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || cmd_ready !== 1'b1) begin
                n_fail++; $display("FAIL mid_after: got valid=%b cyc=%b ready=%b want 0 0 1", rsp_valid, wbm_cyc_o, cmd_ready); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b_adr [3];
        logic [31:0] b_dat [3];
        logic        b_we  [3];
        logic [31:0] b_exp [3];
        int acc_t [3];
        int rsp_t [3];
        int acc_n, rsp_n;
        b_adr[0] = 32'h3000_0100; b_we[0] = 1'b0; b_dat[0] = 32'd0;        b_exp[0] = 32'h6A5A_0100;
        b_adr[1] = 32'h3000_0104; b_we[1] = 1'b1; b_dat[1] = 32'h0000_0011; b_exp[1] = 32'h0000_0000;
        b_adr[2] = 32'h3000_0108; b_we[2] = 1'b0; b_dat[2] = 32'd0;        b_exp[2] = 32'h6A5A_0108;
        acc_n = 0; rsp_n = 0;
        for (int k = 0; k < 3; k++) begin acc_t[k] = -1; rsp_t[k] = -1; end
        slv_adr_mode = 1'b1; slv_waits = 0;
        @(negedge wb_clk_i);
        cmd_valid = 1'b1; cmd_we = b_we[0]; cmd_adr = b_adr[0]; cmd_dat = b_dat[0]; cmd_sel = 4'hF;
        for (int t = 0; t < 30; t++) begin
            if (t > 0) @(negedge wb_clk_i);
            if (rsp_valid === 1'b1) begin
                n_cmp++; if (rsp_n >= 3) begin
                    n_fail++; $display("FAIL b2b_extra: got response %0d want 3 total", rsp_n + 1);
                end else if (rsp_dat !== b_exp[rsp_n] || rsp_err !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_rsp%0d: got dat=%h err=%b want %h 0", rsp_n, rsp_dat, rsp_err, b_exp[rsp_n]); end
                if (rsp_n < 3) rsp_t[rsp_n] = t;
                rsp_n++;
            end
            if (cmd_valid && cmd_ready === 1'b1) begin
                acc_t[acc_n] = t;
                acc_n++;
                @(posedge wb_clk_i); #1;
                if (acc_n < 3) begin
                    cmd_we = b_we[acc_n]; cmd_adr = b_adr[acc_n]; cmd_dat = b_dat[acc_n];
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        n_cmp++; if (acc_n != 3 || rsp_n != 3) begin
            n_fail++; $display("FAIL b2b_count: got acc=%0d rsp=%0d want 3 3", acc_n, rsp_n); end
        n_cmp++; if (acc_t[1] - acc_t[0] != 3 || acc_t[2] - acc_t[1] != 3) begin
            n_fail++; $display("FAIL b2b_rate: got accept at %0d %0d %0d want spacing 3", acc_t[0], acc_t[1], acc_t[2]); end
        n_cmp++; if (rsp_t[0] != acc_t[0] + 2 || rsp_t[1] != acc_t[1] + 2 || rsp_t[2] != acc_t[2] + 2) begin
            n_fail++; $display("FAIL b2b_latency: got rsp at %0d %0d %0d want %0d %0d %0d",
                               rsp_t[0], rsp_t[1], rsp_t[2], acc_t[0] + 2, acc_t[1] + 2, acc_t[2] + 2); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_late_ack();
        test_ack_idle();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
